// File: rtl/inference_sequencer_pkg.sv
// Shared types and constants for the inference sequencer: FSM state encoding,
// default frame geometry and the digit code reported on a watchdog timeout.
package inference_sequencer_pkg;

    typedef enum logic [1:0] {
        INCARCARE = 2'd0,
        RESET_NN  = 2'd1,
        CALCUL    = 2'd2,
        REZULTAT  = 2'd3
    } stare_secv_t;

    localparam int         NUM_PIXELI_DEF = 784;
    localparam int         PIXEL_W_DEF    = 8;
    localparam logic [7:0] COD_EROARE     = 8'hFF;

endpackage

// File: rtl/inference_sequencer_watchdog.sv
// Cycle watchdog: synchronous clear, counts while enabled, raises expirat once
// the count reaches LIMITA and holds there until cleared.
module watchdog_timeout #(
    parameter int LIMITA = 200000
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic expirat
);
    localparam int CNT_W = $clog2(LIMITA + 1);

    logic [CNT_W-1:0] contor;

    always_ff @(posedge clock) begin
        if (clear) begin
            contor <= '0;
        end else if (enable && !expirat) begin
            contor <= contor + CNT_W'(1);
        end
    end

    assign expirat = (contor == CNT_W'(LIMITA));

endmodule

// File: rtl/inference_sequencer.sv
// Sequences one neural_network inference per frame: buffer pixels, pulse nn_reset, run, hand back the digit.
// Optional: define INFERENCE_TIMEOUT_EN to bound CALCUL with a watchdog reporting COD_EROARE and eroare=1.
module inference_sequencer
    import inference_sequencer_pkg::*;
#(
    parameter int NUM_PIXELI    = NUM_PIXELI_DEF,
    parameter int PIXEL_W       = PIXEL_W_DEF,
    parameter int TIMEOUT_CICLI = 200000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic signed [PIXEL_W-1:0] pixel_in,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic signed [PIXEL_W-1:0] imagine [0:NUM_PIXELI-1],
    output logic                      nn_enable,
    output logic                      nn_reset,
    input  logic                      stare_retea,
    input  logic [7:0]                cifra_iesire,
    output logic [7:0]                cifra,
    output logic                      cifra_valid,
    input  logic                      cifra_ready,
    output logic                      eroare,
    output logic [15:0]               nr_imagini
);
    localparam int               IDX_W     = $clog2(NUM_PIXELI);
    localparam logic [IDX_W-1:0] IDX_ULTIM = IDX_W'(NUM_PIXELI - 1);

    stare_secv_t      stare, stare_urm;
    logic [IDX_W-1:0] idx;
    logic             stare_q;
    logic             accept_pixel;
    logic             terminat;
    logic             timeout;

    assign accept_pixel = pixel_valid && pixel_ready;
    // Only a fresh 0->1 edge counts; a status left high from a previous run is ignored.
    assign terminat     = (stare == CALCUL) && stare_retea && !stare_q;
    assign nn_reset     = reset || (stare == RESET_NN);

    always_ff @(posedge clock) begin
        if (reset) begin
            stare   <= INCARCARE;
            stare_q <= 1'b0;
        end else begin
            stare   <= stare_urm;
            stare_q <= stare_retea;
        end
    end

    always_comb begin
        stare_urm   = stare;
        pixel_ready = 1'b0;
        nn_enable   = 1'b0;
        cifra_valid = 1'b0;
        case (stare)
            INCARCARE: begin
                pixel_ready = 1'b1;
                if (pixel_valid && (idx == IDX_ULTIM)) stare_urm = RESET_NN;
            end
            RESET_NN: stare_urm = CALCUL;
            CALCUL: begin
                nn_enable = 1'b1;
                if (terminat || timeout) stare_urm = REZULTAT;
            end
            REZULTAT: begin
                cifra_valid = 1'b1;
                if (cifra_ready) stare_urm = INCARCARE;
            end
            default: stare_urm = INCARCARE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= '0;
        end else if (accept_pixel) begin
            idx <= (idx == IDX_ULTIM) ? '0 : idx + IDX_W'(1);
        end
    end

    // Frame buffer carries no reset; it is written only while loading, so the network sees a frozen image.
    always_ff @(posedge clock) begin
        if (accept_pixel) imagine[idx] <= pixel_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cifra <= '0;
        end else if (terminat) begin
            cifra <= cifra_iesire;
        end else if ((stare == CALCUL) && timeout) begin
            cifra <= COD_EROARE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            nr_imagini <= '0;
        end else if (cifra_valid && cifra_ready) begin
            nr_imagini <= nr_imagini + 16'd1;
        end
    end

`ifdef INFERENCE_TIMEOUT_EN
    watchdog_timeout #(
        .LIMITA (TIMEOUT_CICLI)
    ) u_watchdog (
        .clock   (clock),
        .clear   (reset || (stare != CALCUL)),
        .enable  (stare == CALCUL),
        .expirat (timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            eroare <= 1'b0;
        end else if (terminat) begin
            eroare <= 1'b0;
        end else if ((stare == CALCUL) && timeout) begin
            eroare <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign eroare             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CICLI == 0);
`endif

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench for inference_sequencer: behavioural network model, result queue, per-scenario tasks.
`timescale 1ns/1ps
module tb_inference_sequencer;

    localparam int NP = 784;
    localparam int PW = 8;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic signed [PW-1:0] pixel_in = '0;
    logic                 pixel_valid = 1'b0;
    logic                 pixel_ready;
    logic signed [PW-1:0] imagine [0:NP-1];
    logic                 nn_enable;
    logic                 nn_reset;
    logic                 stare_retea;
    logic [7:0]           cifra_iesire = 8'd0;
    logic [7:0]           cifra;
    logic                 cifra_valid;
    logic                 cifra_ready = 1'b0;
    logic                 eroare;
    logic [15:0]          nr_imagini;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Network model: raises status nn_lat enabled cycles after its reset.
    logic model_on = 1'b1;
    logic model_stare = 1'b0;
    logic man_stare = 1'b0;
    int   nn_lat = 50;
    int   lat_cnt = 0;

    typedef struct packed {
        logic [7:0] cifra;
        logic       eroare;
    } rez_t;

    rez_t                 rez_q[$];
    logic signed [PW-1:0] frame [0:NP-1];

    assign stare_retea = model_on ? model_stare : man_stare;

    inference_sequencer #(
        .NUM_PIXELI    (NP),
        .PIXEL_W       (PW),
        .TIMEOUT_CICLI (100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .imagine      (imagine),
        .nn_enable    (nn_enable),
        .nn_reset     (nn_reset),
        .stare_retea  (stare_retea),
        .cifra_iesire (cifra_iesire),
        .cifra        (cifra),
        .cifra_valid  (cifra_valid),
        .cifra_ready  (cifra_ready),
        .eroare       (eroare),
        .nr_imagini   (nr_imagini)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (nn_reset) begin
            lat_cnt     <= 0;
            model_stare <= 1'b0;
        end else if (nn_enable) begin
            lat_cnt <= lat_cnt + 1;
            if (lat_cnt + 1 == nn_lat) model_stare <= 1'b1;
        end
    end

    // Result monitor: runs just after inputs are driven, so it sees the handshake the next edge will take.
    always begin
        rez_t rez_exp;
        @(negedge clock);
        #1;
        if (nn_reset && !reset) pulses++;
        if (!reset && cifra_valid && cifra_ready) begin
            tests++;
            if (rez_q.size() == 0) begin
                fails++;
                $display("FAIL result_unexpected: got cifra=%0h eroare=%0b, none expected", cifra, eroare);
            end else begin
                rez_exp = rez_q.pop_front();
                if (cifra !== rez_exp.cifra || eroare !== rez_exp.eroare) begin
                    fails++;
                    $display("FAIL result: got cifra=%0h eroare=%0b, want cifra=%0h eroare=%0b",
                             cifra, eroare, rez_exp.cifra, rez_exp.eroare);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic logic signed [PW-1:0] pixel_3(input int k);
        int r;
        int c;
        bit ink;
        r   = k / 28;
        c   = k % 28;
        ink = ((r inside {[4:6], [12:14], [20:22]}) && c >= 8 && c <= 19) ||
              (c >= 17 && c <= 19 && r >= 4 && r <= 22);
        return ink ? 8'sd127 : 8'sh80;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < NP; k++) frame[k] = $signed(PW'($urandom));
    endtask

    task automatic load_frame();
        for (int k = 0; k < NP; k++) begin
            @(negedge clock);
            pixel_in    = frame[k];
            pixel_valid = 1'b1;
        end
    endtask

    task automatic wait_cifra_valid(input int max_cicli);
        int n = 0;
        while (cifra_valid !== 1'b1 && n < max_cicli) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (nn_reset !== 1'b1) begin
            fails++;
            $display("FAIL reset_nn_reset: got %0b want 1", nn_reset);
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (pixel_ready !== 1'b1 || nn_enable !== 1'b0 || nn_reset !== 1'b0 || cifra !== 8'd0 ||
            cifra_valid !== 1'b0 || eroare !== 1'b0 || nr_imagini !== 16'd0) begin
            fails++;
            $display("FAIL reset_values: got rdy=%0b en=%0b nrst=%0b cifra=%0h vld=%0b err=%0b nr=%0d want 1 0 0 0 0 0 0",
                     pixel_ready, nn_enable, nn_reset, cifra, cifra_valid, eroare, nr_imagini);
        end
    endtask

    task automatic test_full_frame();
        int p0;
        int n;
        int bad = 0;
        for (int k = 0; k < NP; k++) frame[k] = pixel_3(k);
        cifra_ready  = 1'b1;
        model_on     = 1'b1;
        nn_lat       = 50;
        cifra_iesire = 8'd3;
        rez_q.push_back({8'd3, 1'b0});
        p0 = pulses;
        load_frame();
        @(negedge clock);
        pixel_valid = 1'b0;
        tests++;
        if (nn_reset !== 1'b1 || nn_enable !== 1'b0 || pixel_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_t1: got nrst=%0b en=%0b rdy=%0b want 1 0 0", nn_reset, nn_enable, pixel_ready);
        end
        @(negedge clock);
        tests++;
        if (nn_reset !== 1'b0 || nn_enable !== 1'b1) begin
            fails++;
            $display("FAIL full_t2: got nrst=%0b en=%0b want 0 1", nn_reset, nn_enable);
        end
        n = 0;
        while (stare_retea !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (stare_retea !== 1'b1 || cifra_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_status_c: got stare=%0b vld=%0b want 1 0", stare_retea, cifra_valid);
        end
        @(negedge clock);
        tests++;
        if (cifra_valid !== 1'b1 || cifra !== 8'd3) begin
            fails++;
            $display("FAIL full_result_c1: got vld=%0b cifra=%0d want 1 3", cifra_valid, cifra);
        end
        @(negedge clock);
        tests++;
        if (pixel_ready !== 1'b1 || nr_imagini !== 16'd1 || pulses - p0 != 1) begin
            fails++;
            $display("FAIL full_after: got rdy=%0b nr=%0d pulses=%0d want 1 1 1", pixel_ready, nr_imagini, pulses - p0);
        end
        for (int k = 0; k < NP; k++) if (imagine[k] !== frame[k]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL full_buffer: got %0d wrong pixels want 0", bad);
        end
    endtask

    task automatic test_throttled();
        int  cnt = 0;
        int  n = 0;
        int  bad = 0;
        int  leak = 0;
        bit  v;
        cifra_ready  = 1'b1;
        nn_lat       = 60;
        cifra_iesire = 8'd6;
        rez_q.push_back({8'd6, 1'b0});
        while (cnt < NP && n < NP * 10) begin
            @(negedge clock);
            n++;
            v           = 1'($urandom_range(0, 1));
            pixel_in    = $signed(PW'($urandom));
            pixel_valid = v;
            if (v && pixel_ready === 1'b1) begin
                frame[cnt] = pixel_in;
                cnt++;
            end
        end
        tests++;
        if (cnt != NP) begin
            fails++;
            $display("FAIL throttle_count: got %0d accepted want %0d", cnt, NP);
        end
        repeat (20) begin
            @(negedge clock);
            if (pixel_ready !== 1'b0) leak++;
            pixel_in    = $signed(PW'($urandom));
            pixel_valid = 1'b1;
        end
        @(negedge clock);
        pixel_valid = 1'b0;
        tests++;
        if (leak != 0) begin
            fails++;
            $display("FAIL throttle_ready_low: got %0d cycles ready=1 want 0", leak);
        end
        for (int k = 0; k < NP; k++) if (imagine[k] !== frame[k]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL throttle_buffer: got %0d wrong pixels want 0", bad);
        end
        n = 0;
        while (pixel_ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (pixel_ready !== 1'b1 || nr_imagini !== 16'd2) begin
            fails++;
            $display("FAIL throttle_done: got rdy=%0b nr=%0d want 1 2", pixel_ready, nr_imagini);
        end
    endtask

    task automatic test_stale_status();
        int bad = 0;
        model_on     = 1'b0;
        man_stare    = 1'b1;
        cifra_ready  = 1'b1;
        cifra_iesire = 8'd9;
        fill_random();
        load_frame();
        @(negedge clock);
        pixel_valid = 1'b0;
        repeat (15) begin
            @(negedge clock);
            if (cifra_valid !== 1'b0 || nn_enable !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stale_ignored: got %0d bad cycles want 0", bad);
        end
        man_stare = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if (cifra_valid !== 1'b0) begin
            fails++;
            $display("FAIL stale_low: got vld=%0b want 0", cifra_valid);
        end
        rez_q.push_back({8'd9, 1'b0});
        man_stare = 1'b1;
        @(negedge clock);
        tests++;
        if (cifra_valid !== 1'b1 || cifra !== 8'd9) begin
            fails++;
            $display("FAIL stale_rise: got vld=%0b cifra=%0d want 1 9", cifra_valid, cifra);
        end
        @(negedge clock);
        tests++;
        if (pixel_ready !== 1'b1 || nr_imagini !== 16'd3) begin
            fails++;
            $display("FAIL stale_done: got rdy=%0b nr=%0d want 1 3", pixel_ready, nr_imagini);
        end
        model_on = 1'b1;
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        model_on     = 1'b1;
        nn_lat       = 10;
        cifra_iesire = 8'd7;
        cifra_ready  = 1'b0;
        rez_q.push_back({8'd7, 1'b0});
        fill_random();
        load_frame();
        @(negedge clock);
        pixel_valid = 1'b0;
        wait_cifra_valid(100);
        tests++;
        if (cifra_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_wait: got vld=%0b want 1", cifra_valid);
        end
        cifra_iesire = 8'd1;
        repeat (20) begin
            @(negedge clock);
            if (cifra_valid !== 1'b1 || cifra !== 8'd7 || pixel_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end
        cifra_ready = 1'b1;
        @(negedge clock);
        tests++;
        if (pixel_ready !== 1'b1 || cifra_valid !== 1'b0 || nr_imagini !== 16'd4) begin
            fails++;
            $display("FAIL bp_release: got rdy=%0b vld=%0b nr=%0d want 1 0 4", pixel_ready, cifra_valid, nr_imagini);
        end
    endtask

    task automatic test_reset_mid_op();
        int bad = 0;
        cifra_ready = 1'b1;
        model_on    = 1'b1;
        nn_lat      = 100000;
        fill_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            pixel_in    = frame[k];
            pixel_valid = 1'b1;
        end
        @(negedge clock);
        pixel_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        tests++;
        if (pixel_ready !== 1'b1 || nn_enable !== 1'b0 || nr_imagini !== 16'd0 || cifra_valid !== 1'b0 || nn_reset !== 1'b1) begin
            fails++;
            $display("FAIL rst_load: got rdy=%0b en=%0b nr=%0d vld=%0b nrst=%0b want 1 0 0 0 1",
                     pixel_ready, nn_enable, nr_imagini, cifra_valid, nn_reset);
        end
        reset = 1'b0;
        fill_random();
        load_frame();
        @(negedge clock);
        pixel_valid = 1'b0;
        repeat (10) @(negedge clock);
        tests++;
        if (nn_enable !== 1'b1) begin
            fails++;
            $display("FAIL rst_calcul_pre: got en=%0b want 1", nn_enable);
        end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (nn_enable !== 1'b0 || pixel_ready !== 1'b1 || nr_imagini !== 16'd0) begin
            fails++;
            $display("FAIL rst_calcul: got en=%0b rdy=%0b nr=%0d want 0 1 0", nn_enable, pixel_ready, nr_imagini);
        end
        reset        = 1'b0;
        nn_lat       = 30;
        cifra_iesire = 8'd5;
        rez_q.push_back({8'd5, 1'b0});
        fill_random();
        load_frame();
        @(negedge clock);
        pixel_valid = 1'b0;
        wait_cifra_valid(200);
        tests++;
        if (cifra_valid !== 1'b1 || cifra !== 8'd5) begin
            fails++;
            $display("FAIL rst_recover: got vld=%0b cifra=%0d want 1 5", cifra_valid, cifra);
        end
        for (int k = 0; k < NP; k++) if (imagine[k] !== frame[k]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rst_buffer: got %0d wrong pixels want 0", bad);
        end
        @(negedge clock);
        tests++;
        if (pixel_ready !== 1'b1 || nr_imagini !== 16'd1) begin
            fails++;
            $display("FAIL rst_count: got rdy=%0b nr=%0d want 1 1", pixel_ready, nr_imagini);
        end
    endtask

`ifdef INFERENCE_TIMEOUT_EN
    task automatic test_timeout();
        model_on    = 1'b0;
        man_stare   = 1'b0;
        cifra_ready = 1'b1;
        rez_q.push_back({8'hFF, 1'b1});
        fill_random();
        load_frame();
        @(negedge clock);
        pixel_valid = 1'b0;
        @(negedge clock);
        tests++;
        if (nn_enable !== 1'b1) begin
            fails++;
            $display("FAIL to_entry: got en=%0b want 1", nn_enable);
        end
        repeat (100) @(negedge clock);
        tests++;
        if (cifra_valid !== 1'b0 || nn_enable !== 1'b1) begin
            fails++;
            $display("FAIL to_early: got vld=%0b en=%0b want 0 1", cifra_valid, nn_enable);
        end
        @(negedge clock);
        tests++;
        if (cifra_valid !== 1'b1 || cifra !== 8'hFF || eroare !== 1'b1 || nn_enable !== 1'b0) begin
            fails++;
            $display("FAIL to_expire: got vld=%0b cifra=%0h err=%0b en=%0b want 1 ff 1 0",
                     cifra_valid, cifra, eroare, nn_enable);
        end
        @(negedge clock);
        tests++;
        if (pixel_ready !== 1'b1 || nr_imagini !== 16'd2) begin
            fails++;
            $display("FAIL to_done: got rdy=%0b nr=%0d want 1 2", pixel_ready, nr_imagini);
        end
        model_on = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_throttled();
        test_stale_status();
        test_back_pressure();
        test_reset_mid_op();
`ifdef INFERENCE_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clock);
        tests++;
        if (rez_q.size() != 0) begin
            fails++;
            $display("FAIL results_pending: got %0d unconsumed want 0", rez_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Controller that sequences one `neural_network` inference per image. It accepts a 28×28 frame as a pixel stream with a valid/ready handshake and buffers it. It then resets and enables the network, waits for its completion status, and returns the recognised digit through a second valid/ready handshake. It sits between the image source (UART/DMA front end) and `neural_network`, and replaces the hand-driven enable/reset sequence used in simulation.

## Interface
Parameters:
- `NUM_PIXELI`, 784, pixels per frame.
- `PIXEL_W`, 8, signed pixel width.
- `TIMEOUT_CICLI`, 200000, watchdog limit in clock cycles (used only with `TIMEOUT_EN`).

Ports:
- `clock`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pixel_in`  in  `PIXEL_W`  signed pixel, raster order.
- `pixel_valid`  in  1  `pixel_in` is valid.
- `pixel_ready`  out  1  sequencer accepts a pixel this cycle.
- `imagine`  out  unpacked `[0:NUM_PIXELI-1]` of `PIXEL_W`  frame buffer driven to the network.
- `nn_enable`  out  1  network enable.
- `nn_reset`  out  1  network reset.
- `stare_retea`  in  1  network status; 1 means result ready.
- `cifra_iesire`  in  8  network result.
- `cifra`  out  8  latched digit.
- `cifra_valid`  out  1  `cifra` is valid.
- `cifra_ready`  in  1  consumer takes `cifra`.
- `eroare`  out  1  qualifies `cifra`; 1 means timeout.
- `nr_imagini`  out  16  count of completed frames; wraps at 2^16.

## Operation
- The FSM states are INCARCARE, RESET_NN, CALCUL, REZULTAT.
- **INCARCARE**
  - `pixel_ready`=1.
  - On `pixel_valid && pixel_ready`: write `imagine[idx]` = `pixel_in`, then idx++.
  - `idx` is a 10-bit counter (`$clog2(NUM_PIXELI)`).
  - Acceptance of pixel `NUM_PIXELI-1` → idx=0, next state RESET_NN.
- **RESET_NN**
  - Lasts exactly 1 cycle, with `nn_reset`=1.
  - Next state is CALCUL.
- **CALCUL**
  - `nn_enable`=1 and `pixel_ready`=0.
  - A registered copy of `stare_retea` gives rising-edge detection.
  - Completion is a 0→1 transition of `stare_retea` sampled in CALCUL. A level already high on entry is ignored.
  - On completion:
    - `cifra` ← `cifra_iesire` and `eroare` ← 0.
    - `nn_enable` drops in the same cycle as the state change.
    - Next state is REZULTAT.
- **REZULTAT**
  - `cifra_valid`=1, held with `cifra` stable until `cifra_ready`.
  - On `cifra_valid && cifra_ready`: `nr_imagini`++ and next state INCARCARE.
- `nn_reset` = `reset` OR (state==RESET_NN), so the network is also cleared during a global reset.
- The frame buffer is not reset and is not writable outside INCARCARE. The network sees a stable image from RESET_NN through REZULTAT.

## Timing
- **Reset values:** state INCARCARE, idx 0, `pixel_ready` 1 in the first cycle after reset deasserts, `nn_enable` 0, `cifra` 0, `cifra_valid` 0, `eroare` 0, `nr_imagini` 0. `imagine` is undefined after reset.
- **Load:** with `pixel_valid` held high, a frame loads in exactly `NUM_PIXELI` cycles.
- **Network start:** last pixel accepted at cycle T → `nn_reset`=1 at T+1, `nn_enable`=1 from T+2.
- **Result:** `stare_retea` rising edge sampled at cycle C → `cifra_valid`=1 at C+1.
- **Return to load:** handshake completes at cycle H → `pixel_ready`=1 at H+1. Back-to-back frames have no dead cycle beyond this.
- **`cifra_ready` held high:** result is consumed in the first REZULTAT cycle.
- **Reset mid-operation:** from any state, return to INCARCARE next cycle, idx=0, a pending result is discarded, `nr_imagini` is cleared.
- **`pixel_valid` outside INCARCARE:** ignored; no write and no idx change.

## Configuration
- `INFERENCE_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in CALCUL.
  - When the count reaches `TIMEOUT_CICLI` without completion: `cifra`=8'hFF, `eroare`=1, `nn_enable` drops, next state REZULTAT. The handshake proceeds as normal.
  - The counter clears on entry to CALCUL.
- `INFERENCE_TIMEOUT_EN` undefined:
  - No counter.
  - CALCUL waits indefinitely.
  - `eroare` is tied to 0.

## Structure
- Package `inference_sequencer_pkg` holds:
  - the FSM state enum `stare_secv_t`;
  - `NUM_PIXELI_DEF`=784 and `PIXEL_W_DEF`=8;
  - `COD_EROARE`=8'hFF.
- One sub-module, `watchdog_timeout` (load-clear counter with an expiry flag), instantiated only under `INFERENCE_TIMEOUT_EN`.
- The FSM, frame buffer, idx and `nr_imagini` stay in the top module.

## Test plan
- **Full frame:** stream 784 pixels with `pixel_valid` always 1 (the handwritten-"3" test vector), network model raising `stare_retea` 50 cycles after enable with `cifra_iesire`=3.
  - `nn_reset` pulses once, at T+1.
  - `cifra`=3 and `cifra_valid` at C+1.
  - After `cifra_ready`, `nr_imagini`=1.
- **Throttled input:** `pixel_valid` random 50%.
  - `imagine[k]` equals the k-th accepted pixel for all k.
  - No acceptance while `pixel_ready`=0.
- **Stale status:** `stare_retea` already 1 when CALCUL is entered.
  - No completion until it falls and rises again.
- **Consumer back-pressure:** `cifra_ready` held 0 for 20 cycles.
  - `cifra` stays stable and `cifra_valid` stays 1.
  - `pixel_ready` stays 0.
- **Reset at pixel 400 and again during CALCUL:**
  - idx returns to 0 and `nn_enable`=0 next cycle.
  - A new full frame completes normally.
- **`INFERENCE_TIMEOUT_EN` with `TIMEOUT_CICLI`=100, network never responds:**
  - `cifra`=8'hFF and `eroare`=1 at 101 cycles after CALCUL entry.
